// File: rtl/logicap_seqcap.sv
// Logic-analyser capture engine: multi-stage trigger sequencer, pre-trigger ring buffer
// and post-trigger counter, streaming one framed capture over AXI-Stream.
module logicap_seqcap #(
  parameter int size          = 32,
  parameter int levels        = 8,
  parameter int pretrig_depth = 256,
  parameter int saddr_w       = 24
) (
  input  logic                             clk,
  input  logic                             resetn,
  input  logic [size-1:0]                  sample_data,
  input  logic                             sample_valid,
  input  logic [levels*size-1:0]           trig_mask,
  input  logic [levels*size-1:0]           trig_type,
  input  logic [levels*size-1:0]           trig_level,
  input  logic [$clog2(levels):0]          num_levels,
  input  logic [$clog2(pretrig_depth):0]   pre_count,
  input  logic [saddr_w-1:0]               post_count,
  input  logic                             arm,
  input  logic                             abort,
  output logic [size-1:0]                  tdata,
  output logic                             tvalid,
  output logic                             tlast,
  input  logic                             tready,
  output logic                             armed,
  output logic                             triggered,
  output logic                             done,
  output logic                             overrun,
  output logic [$clog2(levels)-1:0]        stage
);
  localparam int SW = $clog2(levels);
  localparam int NW = SW + 1;
  localparam int PW = $clog2(pretrig_depth);
  localparam int OW = PW + 1;

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_WAIT  = 3'd1,
    S_POST  = 3'd2,
    S_DRAIN = 3'd3,
    S_DONE  = 3'd4
  } state_t;

  state_t              state_q, state_d;
  logic [SW-1:0]       stage_q, stage_d;
  logic [NW-1:0]       nlev_q, nlev_d;
  logic [OW-1:0]       pre_q, pre_d;
  logic [saddr_w-1:0]  post_q, post_d, cnt_q, cnt_d;
  logic [size-1:0]     prev_q, prev_d;
  logic                prev_ok_q, prev_ok_d;
  logic [PW-1:0]       wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [OW-1:0]       occ_q, occ_d;
  logic                overrun_q, overrun_d;
  logic [size-1:0]     tdata_q, tdata_d;
  logic                tvalid_q, tvalid_d, tlast_q, tlast_d;
  logic                armed_q, armed_d, triggered_q, triggered_d, done_q, done_d;

  logic [size-1:0]     mem [pretrig_depth];

  logic [size-1:0]     cfg_mask_s, cfg_type_s, cfg_level_s;
  logic [size-1:0]     lvl_ok_s, edge_ok_s, bit_ok_s;
  logic                match_s, last_stage_s, full_s, pop_s, fin_s;
  logic                flush_s, want_push_s, slide_s, pop_any_s, wr_en_s;
  logic [size-1:0]     head_s;

  // Stage comparator: an edge bit needs a previous sample since arm, so the first sample never satisfies it.
  always_comb begin
    cfg_mask_s   = trig_mask[int'(stage_q)*size +: size];
    cfg_type_s   = trig_type[int'(stage_q)*size +: size];
    cfg_level_s  = trig_level[int'(stage_q)*size +: size];
    lvl_ok_s     = ~(sample_data ^ cfg_level_s);
    edge_ok_s    = {size{prev_ok_q}} & (prev_q ^ sample_data) & lvl_ok_s;
    bit_ok_s     = ~cfg_mask_s | (~cfg_type_s & lvl_ok_s) | (cfg_type_s & edge_ok_s);
    match_s      = sample_valid && (&bit_ok_s);
    last_stage_s = ({1'b0, stage_q} == (nlev_q - NW'(1)));
    full_s       = (occ_q == OW'(pretrig_depth));
    pop_s        = tvalid_q && tready;
    fin_s        = pop_s && tlast_q;
  end

  // Sequencer, ring-buffer bookkeeping and next values of the registered stream/status outputs.
  always_comb begin
    state_d     = state_q;
    stage_d     = stage_q;
    nlev_d      = nlev_q;
    pre_d       = pre_q;
    post_d      = post_q;
    cnt_d       = cnt_q;
    prev_d      = prev_q;
    prev_ok_d   = prev_ok_q;
    overrun_d   = overrun_q;
    flush_s     = 1'b0;
    want_push_s = 1'b0;
    slide_s     = 1'b0;
    if (abort) begin
      state_d   = S_IDLE;
      stage_d   = '0;
      prev_ok_d = 1'b0;
      flush_s   = 1'b1;
    end else begin
      case (state_q)
        S_IDLE, S_DONE: begin
          if (arm) begin
            state_d   = S_WAIT;
            stage_d   = '0;
            prev_ok_d = 1'b0;
            overrun_d = 1'b0;
            cnt_d     = '0;
            flush_s   = 1'b1;
            if (num_levels == '0) nlev_d = NW'(1);
            else if (num_levels > NW'(levels)) nlev_d = NW'(levels);
            else nlev_d = num_levels;
            if (pre_count > OW'(pretrig_depth)) pre_d = OW'(pretrig_depth);
            else pre_d = pre_count;
            if (post_count == '0) post_d = saddr_w'(1);
            else post_d = post_count;
          end else begin
            state_d = state_q;
          end
        end
        S_WAIT: begin
          if (sample_valid) begin
            prev_d      = sample_data;
            prev_ok_d   = 1'b1;
            want_push_s = 1'b1;
            if (match_s && last_stage_s) begin
              state_d = S_POST;
              cnt_d   = post_q - saddr_w'(1);
            end else if (match_s) begin
              stage_d = stage_q + SW'(1);
              slide_s = (occ_q == pre_q);
            end else begin
              slide_s = (occ_q == pre_q);
            end
          end else begin
            state_d = state_q;
          end
        end
        S_POST: begin
          if (cnt_q == '0) begin
            state_d = fin_s ? S_DONE : S_DRAIN;
          end else if (sample_valid) begin
            want_push_s = 1'b1;
            cnt_d       = cnt_q - saddr_w'(1);
          end else begin
            state_d = state_q;
          end
        end
        S_DRAIN: begin
          if (fin_s || (occ_q == '0)) state_d = S_DONE;
          else state_d = state_q;
        end
        default: begin
          state_d = S_IDLE;
          flush_s = 1'b1;
        end
      endcase
    end

    pop_any_s = pop_s || slide_s;
    wr_en_s   = want_push_s && (!full_s || pop_any_s) && !flush_s;
    if (want_push_s && !wr_en_s && !flush_s) overrun_d = 1'b1;
    else overrun_d = overrun_d;

    if (flush_s) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      occ_d    = '0;
    end else begin
      wr_ptr_d = wr_en_s ? (wr_ptr_q + PW'(1)) : wr_ptr_q;
      rd_ptr_d = pop_any_s ? (rd_ptr_q + PW'(1)) : rd_ptr_q;
      case ({wr_en_s, pop_any_s})
        2'b10:   occ_d = occ_q + OW'(1);
        2'b01:   occ_d = occ_q - OW'(1);
        default: occ_d = occ_q;
      endcase
    end

    // A sample written this cycle into the slot about to become head bypasses the array.
    head_s      = (wr_en_s && (rd_ptr_d == wr_ptr_q)) ? sample_data : mem[rd_ptr_d];
    tvalid_d    = ((state_d == S_POST) || (state_d == S_DRAIN)) && (occ_d != '0);
    tdata_d     = tvalid_d ? head_s : '0;
    tlast_d     = tvalid_d && (cnt_d == '0) && (occ_d == OW'(1));
    armed_d     = (state_d == S_WAIT);
    triggered_d = (state_d == S_POST) || (state_d == S_DRAIN) || (state_d == S_DONE);
    done_d      = (state_d == S_DONE);
  end

  // Sample storage; contents are only meaningful below the occupancy count, so no reset.
  always_ff @(posedge clk) begin
    if (wr_en_s) mem[wr_ptr_q] <= sample_data;
  end

  // State and output registers.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q     <= S_IDLE;
      stage_q     <= '0;
      nlev_q      <= '0;
      pre_q       <= '0;
      post_q      <= '0;
      cnt_q       <= '0;
      prev_q      <= '0;
      prev_ok_q   <= 1'b0;
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      occ_q       <= '0;
      overrun_q   <= 1'b0;
      tdata_q     <= '0;
      tvalid_q    <= 1'b0;
      tlast_q     <= 1'b0;
      armed_q     <= 1'b0;
      triggered_q <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      stage_q     <= stage_d;
      nlev_q      <= nlev_d;
      pre_q       <= pre_d;
      post_q      <= post_d;
      cnt_q       <= cnt_d;
      prev_q      <= prev_d;
      prev_ok_q   <= prev_ok_d;
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      occ_q       <= occ_d;
      overrun_q   <= overrun_d;
      tdata_q     <= tdata_d;
      tvalid_q    <= tvalid_d;
      tlast_q     <= tlast_d;
      armed_q     <= armed_d;
      triggered_q <= triggered_d;
      done_q      <= done_d;
    end
  end

  assign tdata     = tdata_q;
  assign tvalid    = tvalid_q;
  assign tlast     = tlast_q;
  assign armed     = armed_q;
  assign triggered = triggered_q;
  assign done      = done_q;
  assign overrun   = overrun_q;
  assign stage     = stage_q;
endmodule

// File: tb/tb_logicap_seqcap.sv
// Scoreboard bench for logicap_seqcap: directed captures push expected beats, a monitor
// pops and compares on every stream handshake.
module tb_logicap_seqcap;
  localparam int SZ = 32;
  localparam int LV = 8;
  localparam int PD = 8;
  localparam int AW = 24;

  logic               clk;
  logic               resetn;
  logic [SZ-1:0]      sample_data;
  logic               sample_valid;
  logic [LV*SZ-1:0]   trig_mask, trig_type, trig_level;
  logic [3:0]         num_levels;
  logic [3:0]         pre_count;
  logic [AW-1:0]      post_count;
  logic               arm, abort;
  logic [SZ-1:0]      tdata;
  logic               tvalid, tlast, tready;
  logic               armed, triggered, done, overrun;
  logic [2:0]         stage;

  int total = 0;
  int bad   = 0;
  logic [SZ:0] exp_q[$];
  logic [SZ:0] mon_e;

  logicap_seqcap #(.size(SZ), .levels(LV), .pretrig_depth(PD), .saddr_w(AW)) dut (
    .clk(clk), .resetn(resetn), .sample_data(sample_data), .sample_valid(sample_valid),
    .trig_mask(trig_mask), .trig_type(trig_type), .trig_level(trig_level),
    .num_levels(num_levels), .pre_count(pre_count), .post_count(post_count),
    .arm(arm), .abort(abort), .tdata(tdata), .tvalid(tvalid), .tlast(tlast), .tready(tready),
    .armed(armed), .triggered(triggered), .done(done), .overrun(overrun), .stage(stage)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] expv);
    total++;
    if (act !== expv) begin
      bad++;
      $display("FAIL %s: got %0h, want %0h", name, act, expv);
    end
  endtask

  // Monitor: every accepted beat must be the next expected one.
  always @(negedge clk) begin
    if (resetn && tvalid && tready) begin
      if (exp_q.size() == 0) begin
        total++;
        bad++;
        $display("FAIL frame_extra: got beat %0h, want no beat", tdata);
      end else begin
        mon_e = exp_q.pop_front();
        chk("frame_data", {32'd0, tdata}, {32'd0, mon_e[SZ-1:0]});
        chk("frame_last", {63'd0, tlast}, {63'd0, mon_e[SZ]});
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [SZ-1:0] d);
    sample_data  = d;
    sample_valid = 1'b1;
    step();
    sample_valid = 1'b0;
  endtask

  task automatic do_arm();
    arm = 1'b1;
    step();
    arm = 1'b0;
  endtask

  task automatic clear_cfg();
    trig_mask  = '0;
    trig_type  = '0;
    trig_level = '0;
  endtask

  task automatic set_stage(input int k, input logic [SZ-1:0] m, input logic [SZ-1:0] t,
                           input logic [SZ-1:0] l);
    trig_mask[k*SZ +: SZ]  = m;
    trig_type[k*SZ +: SZ]  = t;
    trig_level[k*SZ +: SZ] = l;
  endtask

  task automatic expect_beat(input logic [SZ-1:0] d, input logic last);
    exp_q.push_back({last, d});
  endtask

  task automatic wait_done(input string name);
    int n;
    n = 0;
    while (!done && n < 300) begin
      step();
      n++;
    end
    chk(name, {63'd0, done}, 64'd1);
    chk({name, "_frame_len"}, 64'(exp_q.size()), 64'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, want finish");
    $fatal(1, "watchdog");
  end

  initial begin
    resetn = 1'b0; sample_data = '0; sample_valid = 1'b0; arm = 1'b0; abort = 1'b0;
    tready = 1'b0; num_levels = 4'd1; pre_count = 4'd0; post_count = 24'd1;
    clear_cfg();
    repeat (3) step();
    chk("rst_tvalid", {63'd0, tvalid}, 64'd0);
    chk("rst_status", {60'd0, armed, triggered, done, overrun}, 64'd0);
    chk("rst_stage", {61'd0, stage}, 64'd0);
    resetn = 1'b1;
    step();

    // 1: trigger on sample 1, pre window short.
    set_stage(0, 32'h1, 32'h0, 32'h1);
    num_levels = 4'd1; pre_count = 4'd4; post_count = 24'd3; tready = 1'b1;
    expect_beat(32'd0, 1'b0); expect_beat(32'd1, 1'b0);
    expect_beat(32'd2, 1'b0); expect_beat(32'd3, 1'b1);
    do_arm();
    chk("t1_armed", {63'd0, armed}, 64'd1);
    for (int i = 0; i < 16; i++) send(32'(i));
    wait_done("t1_done");

    // 2: trigger on 9 with stalled stream, then drain.
    clear_cfg();
    set_stage(0, 32'hF, 32'h0, 32'h9);
    tready = 1'b0;
    for (int i = 5; i < 12; i++) expect_beat(32'(i), (i == 11));
    do_arm();
    for (int i = 0; i < 9; i++) send(32'(i));
    chk("t2_pre_trig_tvalid", {63'd0, tvalid}, 64'd0);
    chk("t2_pre_trig_triggered", {63'd0, triggered}, 64'd0);
    for (int i = 9; i < 16; i++) send(32'(i));
    chk("t2_triggered", {63'd0, triggered}, 64'd1);
    chk("t2_stall_head", {32'd0, tdata}, 64'h5);
    step(); step();
    chk("t2_stall_hold", {32'd0, tdata}, 64'h5);
    tready = 1'b1;
    wait_done("t2_done");
    chk("t2_overrun", {63'd0, overrun}, 64'd0);

    // 3: three-stage sequence; out-of-order matches must not advance.
    clear_cfg();
    set_stage(0, 32'h1, 32'h1, 32'h1);
    set_stage(1, 32'h2, 32'h2, 32'h0);
    set_stage(2, 32'hFF, 32'h0, 32'hA5);
    num_levels = 4'd3; pre_count = 4'd2; post_count = 24'd2;
    expect_beat(32'hA5, 1'b0); expect_beat(32'h25, 1'b0);
    expect_beat(32'hA5, 1'b0); expect_beat(32'h11, 1'b1);
    do_arm();
    send(32'h01); chk("t3_first_edge", {61'd0, stage}, 64'd0);
    send(32'hA5); chk("t3_ooo_level", {61'd0, stage}, 64'd0);
    send(32'h02); chk("t3_ooo_rise1", {61'd0, stage}, 64'd0);
    send(32'h03); chk("t3_stage1", {61'd0, stage}, 64'd1);
    send(32'hA7); chk("t3_no_fall", {61'd0, stage}, 64'd1);
    send(32'hA5); chk("t3_stage2", {61'd0, stage}, 64'd2);
    send(32'h25); chk("t3_no_trig", {63'd0, triggered}, 64'd0);
    send(32'hA5); chk("t3_trig", {63'd0, triggered}, 64'd1);
    send(32'h11);
    wait_done("t3_done");

    // 4: full buffer, remaining post samples dropped; num_levels 0 and pre 15 clamp.
    clear_cfg();
    set_stage(0, 32'hFF, 32'h0, 32'h20);
    num_levels = 4'd0; pre_count = 4'd15; post_count = 24'd10; tready = 1'b0;
    for (int i = 8'h18; i < 8'h20; i++) expect_beat(32'(i), (i == 8'h1F));
    do_arm();
    for (int i = 8'h10; i < 8'h2A; i++) send(32'(i));
    step();
    chk("t4_overrun", {63'd0, overrun}, 64'd1);
    chk("t4_head", {32'd0, tdata}, 64'h18);
    chk("t4_not_last", {63'd0, tlast}, 64'd0);
    tready = 1'b1;
    wait_done("t4_done");

    // 5: abort in POST with a stalled stream, then a clean recapture.
    clear_cfg();
    set_stage(0, 32'hFF, 32'h0, 32'h40);
    num_levels = 4'd1; pre_count = 4'd3; post_count = 24'd5; tready = 1'b0;
    do_arm();
    chk("t5_overrun_clr", {63'd0, overrun}, 64'd0);
    send(32'h3E); send(32'h3F); send(32'h40); send(32'h41);
    chk("t5_tvalid_post", {63'd0, tvalid}, 64'd1);
    chk("t5_head", {32'd0, tdata}, 64'h3E);
    abort = 1'b1; step(); abort = 1'b0;
    chk("t5_abort_tvalid", {63'd0, tvalid}, 64'd0);
    chk("t5_abort_status", {61'd0, armed, triggered, done}, 64'd0);
    tready = 1'b1;
    for (int i = 8'h3E; i < 8'h45; i++) expect_beat(32'(i), (i == 8'h44));
    do_arm();
    for (int i = 8'h3E; i < 8'h45; i++) send(32'(i));
    wait_done("t5_done");

    // 6: async reset mid-DRAIN, then an edge stage ignoring the first sample.
    set_stage(0, 32'hFF, 32'h0, 32'h50);
    pre_count = 4'd2; post_count = 24'd1; tready = 1'b0;
    do_arm();
    send(32'h4E); send(32'h4F); send(32'h50);
    step();
    chk("t6_drain_tvalid", {63'd0, tvalid}, 64'd1);
    #2 resetn = 1'b0;
    #1;
    chk("t6_rst_tvalid", {62'd0, tvalid, tlast}, 64'd0);
    chk("t6_rst_tdata", {32'd0, tdata}, 64'd0);
    chk("t6_rst_status", {57'd0, armed, triggered, done, overrun, stage}, 64'd0);
    step();
    resetn = 1'b1;
    step();
    clear_cfg();
    set_stage(0, 32'h1, 32'h1, 32'h1);
    pre_count = 4'd0; post_count = 24'd1; tready = 1'b1;
    expect_beat(32'h01, 1'b1);
    do_arm();
    send(32'h01); chk("t6_first_edge", {63'd0, triggered}, 64'd0);
    send(32'h00); chk("t6_fall", {63'd0, triggered}, 64'd0);
    send(32'h01); chk("t6_rise", {63'd0, triggered}, 64'd1);
    wait_done("t6_done");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
